// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Purpose  : Shared Y86-64 encodings for the execute stage: status codes,
//            instruction codes, ALU function codes, register "none" ID and
//            the nop image loaded by reset or bubble.
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // One-hot status encodings
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    // Instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // ALU function codes (same values as OPq ifun)
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Register ID meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Nop image fields
    localparam logic [3:0] NOP_ICODE = ICODE_NOP;
    localparam logic [3:0] NOP_IFUN  = 4'h0;
    localparam logic [3:0] NOP_STAT  = STAT_AOK;

    // Condition codes {ZF, SF, OF} after reset
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/y86_alu.sv
`default_nettype none
// ============================================================================
// Module   : y86_alu
// Purpose  : Combinational Y86-64 ALU. Computes valE = B op A and the
//            resulting {ZF, SF, OF} flags. Unsupported function codes give 0.
// Revision : 1.0 - initial release
// ============================================================================
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alufun,
    output logic [WIDTH-1:0] val_e,
    output logic [2:0]       flags
);

    logic of;

    // Result and flags; overflow is judged from operand and result signs
    always_comb begin
        val_e = '0;
        of    = 1'b0;
        case (alufun)
            ALU_ADD: begin
                val_e = alu_b + alu_a;
                of    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                        (val_e[WIDTH-1] != alu_a[WIDTH-1]);
            end
            ALU_SUB: begin
                val_e = alu_b - alu_a;
                of    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                        (val_e[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALU_AND: val_e = alu_a & alu_b;
            ALU_XOR: val_e = alu_a ^ alu_b;
            default: val_e = '0;
        endcase
        flags = {(val_e == '0), val_e[WIDTH-1], of};
    end

endmodule : y86_alu
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Pipelined Y86-64 Execute stage: E pipeline register, ALU operand
//            selection, condition-code register and branch/cmov condition.
//            Optional performance counters when EXEC_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_bubble,
    input  logic             E_stall,
    input  logic [3:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [WIDTH-1:0] d_valC,
    input  logic [WIDTH-1:0] d_valA,
    input  logic [WIDTH-1:0] d_valB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [3:0]       e_stat,
    output logic [3:0]       e_icode,
    output logic             e_Cnd,
    output logic [WIDTH-1:0] e_valE,
    output logic [WIDTH-1:0] e_valA,
    output logic [3:0]       e_dstE,
    output logic [3:0]       e_dstM,
    output logic [2:0]       cc
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [63:0]      perf_insn,
    output logic [63:0]      perf_taken
`endif
);

    localparam logic [WIDTH-1:0] MINUS_EIGHT = {{(WIDTH-4){1'b1}}, 4'b1000};
    localparam logic [WIDTH-1:0] PLUS_EIGHT  = WIDTH'(8);

    logic [3:0]       E_stat;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valC;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [3:0]       E_dstE;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alufun;
    logic [2:0]       new_flags;
    logic             set_cc;
    logic             cnd;

    // E pipeline register: stall has priority over bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            E_stat  <= NOP_STAT;
            E_icode <= NOP_ICODE;
            E_ifun  <= NOP_IFUN;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (E_stall) begin
            E_stat  <= E_stat;
        end else if (E_bubble) begin
            E_stat  <= NOP_STAT;
            E_icode <= NOP_ICODE;
            E_ifun  <= NOP_IFUN;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else begin
            E_stat  <= d_stat;
            E_icode <= d_icode;
            E_ifun  <= d_ifun;
            E_valC  <= d_valC;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

    // ALU operand and function selection by instruction class
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alufun = ALU_ADD;
        case (E_icode)
            ICODE_RRMOVQ, ICODE_OPQ:                alu_a = E_valA;
            ICODE_IRMOVQ, ICODE_RMMOVQ,
            ICODE_MRMOVQ:                           alu_a = E_valC;
            ICODE_CALL, ICODE_PUSHQ:                alu_a = MINUS_EIGHT;
            ICODE_RET, ICODE_POPQ:                  alu_a = PLUS_EIGHT;
            default:                                alu_a = '0;
        endcase
        case (E_icode)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ,
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ,
            ICODE_POPQ:                             alu_b = E_valB;
            default:                                alu_b = '0;
        endcase
        if (E_icode == ICODE_OPQ) begin
            alufun = E_ifun;
        end
    end

    y86_alu #(
        .WIDTH  (WIDTH)
    ) u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alufun (alufun),
        .val_e  (e_valE),
        .flags  (new_flags)
    );

    // Only an OPq updates flags, and only if nothing downstream has faulted
    assign set_cc = (E_icode == ICODE_OPQ) && (m_stat == STAT_AOK) &&
                    (W_stat == STAT_AOK);

    // Condition-code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc <= CC_RESET;
        end else if (set_cc) begin
            cc <= new_flags;
        end
    end

    // Branch / cmov condition from the current (pre-update) flags
    always_comb begin
        logic zf, sf, of, lt;
        zf  = cc[2];
        sf  = cc[1];
        of  = cc[0];
        lt  = sf ^ of;
        cnd = 1'b0;
        case (E_ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = lt | zf;
            4'h2:    cnd = lt;
            4'h3:    cnd = zf;
            4'h4:    cnd = ~zf;
            4'h5:    cnd = ~lt;
            4'h6:    cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

    assign e_Cnd   = cnd;
    assign e_dstE  = ((E_icode == ICODE_RRMOVQ) && !cnd) ? RNONE : E_dstE;
    assign e_dstM  = E_dstM;
    assign e_valA  = E_valA;
    assign e_stat  = E_stat;
    assign e_icode = E_icode;

`ifdef EXEC_PERF_CNT_EN
    logic insn_event;
    logic taken_event;

    assign insn_event  = (E_icode != ICODE_NOP) && (E_stat == STAT_AOK) && !E_stall;
    assign taken_event = insn_event && cnd &&
                         ((E_icode == ICODE_RRMOVQ) || (E_icode == ICODE_JXX));

    // Retired-instruction and taken-condition counters; a stalled
    // instruction is counted once, when it leaves E
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_insn  <= '0;
            perf_taken <= '0;
        end else begin
            if (insn_event) begin
                perf_insn <= perf_insn + 64'd1;
            end
            if (taken_event) begin
                perf_taken <= perf_taken + 64'd1;
            end
        end
    end
`endif

endmodule : execute_stage
`default_nettype wire
